// File: rtl/fft16_input_framer.sv
`default_nettype none
// ============================================================================
// fft16_input_framer : serial-to-parallel ping-pong framer feeding the FFT16
//                      first butterfly. Optional macro FFT16_FRAME_SYNC_EN
//                      adds in_sof resynchronisation and the sync_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module fft16_input_framer #(
   parameter int N     = 16,
   parameter int W     = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
`ifdef FFT16_FRAME_SYNC_EN
   input  logic             in_sof,
   output logic             sync_err,
`endif
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [N*W-1:0]   frame_data,
   output logic [CNT_W-1:0] frame_count
);

   localparam int          IW       = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [W-1:0]     bank_q [2][N];
   logic [W-1:0]     bank_d [2][N];
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IW-1:0]    wr_idx_q, wr_idx_d;
   logic [1:0]       full_q, full_d;
   logic [CNT_W-1:0] frame_count_q, frame_count_d;
   logic             sync_err_q, sync_err_d;
   logic             accept;
   logic             handoff;
   logic             sof;

`ifdef FFT16_FRAME_SYNC_EN
   assign sof      = in_sof;
   assign sync_err = sync_err_q;
`else
   assign sof = 1'b0;
`endif

   assign in_ready    = ~full_q[wr_bank_q];
   assign frame_valid = full_q[rd_bank_q];
   assign frame_count = frame_count_q;
   assign accept      = in_valid & in_ready;
   assign handoff     = frame_valid & frame_ready;

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign frame_data[k*W +: W] = bank_q[rd_bank_q][k];
   end

   // Handoff and completion never touch the same bank, so both updates apply.
   always_comb begin
      bank_d        = bank_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      wr_idx_d      = wr_idx_q;
      full_d        = full_q;
      frame_count_d = frame_count_q;
      sync_err_d    = 1'b0;
      if (handoff) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         frame_count_d     = frame_count_q + CNT_W'(1);
      end
      if (accept) begin
         if (sof) begin
            // Restart the fill bank at index 0; held frames are left alone.
            bank_d[wr_bank_q][0] = in_data;
            wr_idx_d             = IW'(1);
            sync_err_d           = (wr_idx_q != '0);
         end else begin
            bank_d[wr_bank_q][wr_idx_q] = in_data;
            if (wr_idx_q == LAST_IDX) begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = ~wr_bank_q;
               wr_idx_d          = '0;
            end else begin
               wr_idx_d = wr_idx_q + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q        <= '{default: '0};
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         wr_idx_q      <= '0;
         full_q        <= 2'b00;
         frame_count_q <= '0;
         sync_err_q    <= 1'b0;
      end else begin
         bank_q        <= bank_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         wr_idx_q      <= wr_idx_d;
         full_q        <= full_d;
         frame_count_q <= frame_count_d;
         sync_err_q    <= sync_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft16_input_framer.sv
`default_nettype none
// ============================================================================
// tb_fft16_input_framer : directed + random stimulus against a frame-queue
//                         reference model. Honours FFT16_FRAME_SYNC_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft16_input_framer;

   localparam int N     = 16;
   localparam int W     = 16;
   localparam int CNT_W = 16;
`ifdef FFT16_FRAME_SYNC_EN
   localparam bit SOF_EN = 1'b1;
`else
   localparam bit SOF_EN = 1'b0;
`endif

   typedef logic [N*W-1:0] frame_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             in_sof = 1'b0;
   logic             sync_err_obs;
   logic             frame_valid;
   logic             frame_ready = 1'b0;
   logic [N*W-1:0]   frame_data;
   logic [CNT_W-1:0] frame_count;

   fft16_input_framer #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
`ifdef FFT16_FRAME_SYNC_EN
      .in_sof      (in_sof),
      .sync_err    (sync_err_obs),
`endif
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .frame_count (frame_count)
   );

`ifndef FFT16_FRAME_SYNC_EN
   assign sync_err_obs = 1'b0;
`endif

   always #5 clk = ~clk;

   // Reference model: completed frames awaiting handoff, plus the partial frame.
   frame_t       mq[$];
   logic [W-1:0] part[$];
   int unsigned  mcount;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input frame_t obs, input frame_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t pack_part();
      frame_t f = '0;
      for (int k = 0; k < N; k++) f[k*W +: W] = part[k];
      return f;
   endfunction

   // One clock: inputs applied at the negedge, outputs checked 1 time unit after the posedge.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic s, input logic fr);
      logic acc, hand, serr;
      in_valid = v; in_data = d; in_sof = s; frame_ready = fr;
      #1;
      chk("in_ready_pre", frame_t'(in_ready), frame_t'(mq.size() < 2));
      acc  = v && (mq.size() < 2);
      hand = fr && (mq.size() > 0);
      serr = SOF_EN && acc && s && (part.size() != 0);
      @(posedge clk);
      #1;
      if (hand) begin
         void'(mq.pop_front());
         mcount++;
      end
      if (acc) begin
         if (SOF_EN && s) part.delete();
         part.push_back(d);
         if (part.size() == N) begin
            mq.push_back(pack_part());
            part.delete();
         end
      end
      chk("frame_valid", frame_t'(frame_valid), frame_t'(mq.size() > 0));
      chk("frame_count", frame_t'(frame_count), frame_t'(mcount[CNT_W-1:0]));
      chk("in_ready", frame_t'(in_ready), frame_t'(mq.size() < 2));
      chk("sync_err", frame_t'(sync_err_obs), frame_t'(serr));
      if (mq.size() > 0) chk("frame_data", frame_data, mq[0]);
      @(negedge clk);
   endtask

   // Reset is asserted away from any clock edge; outputs must clear immediately.
   task automatic do_reset();
      in_valid = 1'b0; frame_ready = 1'b0; in_sof = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_in_ready", frame_t'(in_ready), frame_t'(1'b1));
      chk("rst_frame_valid", frame_t'(frame_valid), frame_t'(1'b0));
      chk("rst_frame_data", frame_data, '0);
      chk("rst_frame_count", frame_t'(frame_count), '0);
      chk("rst_sync_err", frame_t'(sync_err_obs), frame_t'(1'b0));
      mq.delete(); part.delete(); mcount = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] sv[4];
      #2;
      do_reset();

      // Single frame 0x0001..0x0010, then one handoff pulse.
      for (int i = 1; i <= N; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
      chk("t2_lane0", frame_t'(frame_data[15:0]), frame_t'(16'h0001));
      chk("t2_lane15", frame_t'(frame_data[255:240]), frame_t'(16'h0010));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("t2_count", frame_t'(frame_count), frame_t'(1));

      // Backpressure: 40 offered samples, both banks fill, then one handoff.
      for (int i = 0; i < 40; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
      chk("t3_stalled", frame_t'(in_ready), frame_t'(1'b0));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("t3_ready_back", frame_t'(in_ready), frame_t'(1'b1));
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Signed extremes pass through bit-exact.
      do_reset();
      sv[0] = 16'h8000; sv[1] = 16'h7FFF; sv[2] = 16'hFFFF; sv[3] = 16'h0001;
      for (int i = 0; i < N; i++) cycle(1'b1, sv[i % 4], 1'b0, 1'b0);
      chk("t4_lane0", frame_t'(frame_data[15:0]), frame_t'(16'h8000));
      chk("t4_lane1", frame_t'(frame_data[31:16]), frame_t'(16'h7FFF));
      chk("t4_lane2", frame_t'(frame_data[47:32]), frame_t'(16'hFFFF));

      // Completion of bank B coincides with handoff of bank A.
      for (int i = 0; i < N - 1; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 16'h5A5A, 1'b0, 1'b1);
      chk("t5_lane15", frame_t'(frame_data[255:240]), frame_t'(16'h5A5A));
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Random traffic, with a mid-stream reset partway through.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 20) == 0,
               ($urandom % 3) == 0);
      end

      // Start-of-frame resynchronisation (or its absence without the macro).
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0B00 + W'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'h0A0A, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) cycle(1'b1, 16'h0C00 + W'(i), 1'b0, 1'b0);
      chk("t6_valid", frame_t'(frame_valid), frame_t'(1'b1));
      if (SOF_EN) begin
         chk("t6_lane0", frame_t'(frame_data[15:0]), frame_t'(16'h0A0A));
         chk("t6_lane1", frame_t'(frame_data[31:16]), frame_t'(16'h0C00));
      end else begin
         chk("t6_lane0", frame_t'(frame_data[15:0]), frame_t'(16'h0B00));
         chk("t6_lane1", frame_t'(frame_data[31:16]), frame_t'(16'h0B01));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
